// File: rtl/chr_bg_pkg.sv
// chr_bg_pkg: shared constants and map-entry field helpers for the tile-map background layer
package chr_bg_pkg;
    localparam int SCALE_UNITY    = 8;
    localparam int OFFSET_BITS    = 16;
    localparam int CHR_BG_LATENCY = 6;
    localparam int MAP_NAME_LSB   = 0;

    // Map entry layout is {vflip, hflip, pal_sel, name}; field positions depend on the widths.
    function automatic int map_pal_lsb(input int name_bits);
        return name_bits;
    endfunction

    function automatic int map_hflip_bit(input int name_bits, input int pal_bits);
        return name_bits + pal_bits;
    endfunction

    function automatic int map_vflip_bit(input int name_bits, input int pal_bits);
        return name_bits + pal_bits + 1;
    endfunction
endpackage

// File: rtl/chr_bg_layer_sc_ram.sv
// sc_ram: single-clock simple dual-port RAM, read-first, contents not reset
//   i_clk            clock
//   i_we/i_waddr/i_din  write port
//   i_raddr/o_dout   synchronous read port (one cycle latency)
module sc_ram
    import chr_bg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_dout
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_dout;

    // Both updates are non-blocking, so a colliding read returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_din;
        r_dout <= r_mem[i_raddr];
    end

    assign o_dout = r_dout;
endmodule

// File: rtl/chr_bg_layer.sv
// chr_bg_layer: scrolled/scaled tile-map background, one colour per pixel, 6-cycle latency
//   i_clk, i_reset            pixel clock, async active-high reset
//   i_map_*, i_bmp_*, i_pal_* CPU write ports (map addr = {ty, tx}, row-major)
//   i_scroll_*, i_scale_*, i_clip_en, i_transp_en  shadowed on i_frame_start
//   i_pixel_valid, i_count_*  pixel request
//   o_color, o_opaque, o_color_valid  pixel result
module chr_bg_layer
    import chr_bg_pkg::*;
#(
    parameter int MAP_W_BITS   = 6,
    parameter int MAP_H_BITS   = 6,
    parameter int TILE_BITS    = 3,
    parameter int NAME_BITS    = 8,
    parameter int BPP          = 2,
    parameter int PAL_SEL_BITS = 2,
    parameter int COLOR_BITS   = 8
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_map_we,
    input  logic [MAP_W_BITS+MAP_H_BITS-1:0]   i_map_addr,
    input  logic [NAME_BITS+PAL_SEL_BITS+1:0]  i_map_din,
    input  logic                               i_bmp_we,
    input  logic [NAME_BITS+2*TILE_BITS-1:0]   i_bmp_addr,
    input  logic [BPP-1:0]                     i_bmp_din,
    input  logic                               i_pal_we,
    input  logic [PAL_SEL_BITS+BPP-1:0]        i_pal_addr,
    input  logic [COLOR_BITS-1:0]              i_pal_din,
    input  logic [OFFSET_BITS-1:0]             i_scroll_x,
    input  logic [OFFSET_BITS-1:0]             i_scroll_y,
    input  logic [3:0]                         i_scale_x,
    input  logic [3:0]                         i_scale_y,
    input  logic                               i_clip_en,
    input  logic                               i_transp_en,
    input  logic                               i_frame_start,
    input  logic                               i_pixel_valid,
    input  logic [OFFSET_BITS-1:0]             i_count_h,
    input  logic [OFFSET_BITS-1:0]             i_count_v,
    output logic [COLOR_BITS-1:0]              o_color,
    output logic                               o_opaque,
    output logic                               o_color_valid
);
    localparam int MAP_AW = MAP_W_BITS + MAP_H_BITS;
    localparam int MAP_DW = NAME_BITS + PAL_SEL_BITS + 2;
    localparam int BMP_AW = NAME_BITS + 2 * TILE_BITS;
    localparam int PAL_AW = PAL_SEL_BITS + BPP;
    localparam int X_EXT  = 1 << (TILE_BITS + MAP_W_BITS);
    localparam int Y_EXT  = 1 << (TILE_BITS + MAP_H_BITS);
    localparam int PAL_LSB = map_pal_lsb(NAME_BITS);
    localparam int HF_BIT  = map_hflip_bit(NAME_BITS, PAL_SEL_BITS);
    localparam int VF_BIT  = map_vflip_bit(NAME_BITS, PAL_SEL_BITS);

    logic [OFFSET_BITS-1:0] r_scroll_x, r_scroll_y;
    logic [3:0]             r_scale_x, r_scale_y;
    logic                   r_clip_en, r_transp_en;

    logic                   r1_valid, r1_clip, r1_transp;
    logic [OFFSET_BITS-1:0] r1_dx, r1_dy;
    logic [3:0]             r1_scale_x, r1_scale_y;

    logic                   r2_valid, r2_clip, r2_transp;
    logic [MAP_W_BITS-1:0]  r2_tx;
    logic [MAP_H_BITS-1:0]  r2_ty;
    logic [TILE_BITS-1:0]   r2_ox, r2_oy;

    logic                   r3_valid, r3_clip, r3_transp;
    logic [MAP_AW-1:0]      r3_map_addr;
    logic [TILE_BITS-1:0]   r3_ox, r3_oy;

    logic                   r4_valid, r4_clip, r4_transp;
    logic [TILE_BITS-1:0]   r4_ox, r4_oy;

    logic                   r5_valid, r5_clip, r5_transp;
    logic [PAL_SEL_BITS-1:0] r5_pal;

    logic [COLOR_BITS-1:0]  r6_color;
    logic                   r6_opaque, r6_valid;

    logic [COLOR_BITS-1:0]  r_pal [2**PAL_AW];

    logic signed [31:0]     w_dx, w_dy, w_sx, w_sy;
    logic                   w_out;
    logic [MAP_DW-1:0]      w_map_entry;
    logic [TILE_BITS-1:0]   w_ox, w_oy;
    logic [BMP_AW-1:0]      w_bmp_addr;
    logic [BPP-1:0]         w_pix;

    // Shadow registers: a pixel sharing the frame_start cycle still sees the old values,
    // and each pixel carries its own copy of scale/clip/transp down the pipe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scroll_x  <= '0;
            r_scroll_y  <= '0;
            r_scale_x   <= 4'(SCALE_UNITY);
            r_scale_y   <= 4'(SCALE_UNITY);
            r_clip_en   <= 1'b0;
            r_transp_en <= 1'b0;
        end else if (i_frame_start) begin
            r_scroll_x  <= i_scroll_x;
            r_scroll_y  <= i_scroll_y;
            r_scale_x   <= i_scale_x;
            r_scale_y   <= i_scale_y;
            r_clip_en   <= i_clip_en;
            r_transp_en <= i_transp_en;
        end
    end

    assign w_dx  = {{(32-OFFSET_BITS){r1_dx[OFFSET_BITS-1]}}, r1_dx};
    assign w_dy  = {{(32-OFFSET_BITS){r1_dy[OFFSET_BITS-1]}}, r1_dy};
    assign w_sx  = (w_dx <<< r1_scale_x) >>> SCALE_UNITY;
    assign w_sy  = (w_dy <<< r1_scale_y) >>> SCALE_UNITY;
    assign w_out = (w_sx < 0) || (w_sx >= X_EXT) || (w_sy < 0) || (w_sy >= Y_EXT);

    assign w_ox       = w_map_entry[HF_BIT] ? ~r4_ox : r4_ox;
    assign w_oy       = w_map_entry[VF_BIT] ? ~r4_oy : r4_oy;
    assign w_bmp_addr = {w_map_entry[MAP_NAME_LSB +: NAME_BITS], w_oy, w_ox};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r1_valid <= 1'b0; r1_clip <= 1'b0; r1_transp <= 1'b0;
            r1_dx <= '0; r1_dy <= '0; r1_scale_x <= '0; r1_scale_y <= '0;
            r2_valid <= 1'b0; r2_clip <= 1'b0; r2_transp <= 1'b0;
            r2_tx <= '0; r2_ty <= '0; r2_ox <= '0; r2_oy <= '0;
            r3_valid <= 1'b0; r3_clip <= 1'b0; r3_transp <= 1'b0;
            r3_map_addr <= '0; r3_ox <= '0; r3_oy <= '0;
            r4_valid <= 1'b0; r4_clip <= 1'b0; r4_transp <= 1'b0;
            r4_ox <= '0; r4_oy <= '0;
            r5_valid <= 1'b0; r5_clip <= 1'b0; r5_transp <= 1'b0; r5_pal <= '0;
            r6_color <= '0; r6_opaque <= 1'b0; r6_valid <= 1'b0;
        end else begin
            r1_valid   <= i_pixel_valid;
            r1_dx      <= i_count_h - r_scroll_x;
            r1_dy      <= i_count_v - r_scroll_y;
            r1_scale_x <= r_scale_x;
            r1_scale_y <= r_scale_y;
            r1_clip    <= r_clip_en;
            r1_transp  <= r_transp_en;
            // Wrap mode simply drops the upper bits of s.
            r2_valid  <= r1_valid;
            r2_clip   <= r1_clip && w_out;
            r2_transp <= r1_transp;
            r2_tx     <= w_sx[TILE_BITS +: MAP_W_BITS];
            r2_ty     <= w_sy[TILE_BITS +: MAP_H_BITS];
            r2_ox     <= w_sx[TILE_BITS-1:0];
            r2_oy     <= w_sy[TILE_BITS-1:0];
            r3_valid    <= r2_valid;
            r3_clip     <= r2_clip;
            r3_transp   <= r2_transp;
            r3_map_addr <= {r2_ty, r2_tx};
            r3_ox       <= r2_ox;
            r3_oy       <= r2_oy;
            r4_valid  <= r3_valid;
            r4_clip   <= r3_clip;
            r4_transp <= r3_transp;
            r4_ox     <= r3_ox;
            r4_oy     <= r3_oy;
            r5_valid  <= r4_valid;
            r5_clip   <= r4_clip;
            r5_transp <= r4_transp;
            r5_pal    <= w_map_entry[PAL_LSB +: PAL_SEL_BITS];
            r6_valid  <= r5_valid;
            r6_color  <= r5_clip ? '0 : r_pal[{r5_pal, w_pix}];
            r6_opaque <= !(r5_clip || (r5_transp && w_pix == '0));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 2**PAL_AW; i++) r_pal[i] <= '0;
        end else if (i_pal_we) begin
            r_pal[i_pal_addr] <= i_pal_din;
        end
    end

    sc_ram #(.DATA_WIDTH(MAP_DW), .ADDR_WIDTH(MAP_AW)) u_map_ram (
        .i_clk   (i_clk),
        .i_we    (i_map_we),
        .i_waddr (i_map_addr),
        .i_din   (i_map_din),
        .i_raddr (r3_map_addr),
        .o_dout  (w_map_entry)
    );

    sc_ram #(.DATA_WIDTH(BPP), .ADDR_WIDTH(BMP_AW)) u_bmp_ram (
        .i_clk   (i_clk),
        .i_we    (i_bmp_we),
        .i_waddr (i_bmp_addr),
        .i_din   (i_bmp_din),
        .i_raddr (w_bmp_addr),
        .o_dout  (w_pix)
    );

    assign o_color       = r6_color;
    assign o_opaque      = r6_opaque;
    assign o_color_valid = r6_valid;
endmodule
